// File: rtl/scan_timer_sched.sv
// scan_timer_sched: NUM_CH 16-bit countdown timers serviced one channel per
// cycle by a single shared decrementer. A timebase tick launches a sweep; expired
// channels are queued and offered round-robin on a valid/ready port.
// Optional build macro: SCAN_TMR_AUTORELOAD_EN (periodic timers with reload).

module minus_one #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] y,
  output logic              borrow
);
  // One extra bit catches the borrow out of the MSB.
  assign {borrow, y} = {1'b0, a} - {{DATA_W{1'b0}}, 1'b1};
endmodule

module scan_timer_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_load_vld,
  input  logic [CH_W-1:0]   i_load_ch,
  input  logic [15:0]       i_load_val,
  input  logic              i_cancel_vld,
  input  logic [CH_W-1:0]   i_cancel_ch,
  output logic              o_expire_vld,
  output logic [CH_W-1:0]   o_expire_ch,
  input  logic              i_expire_rdy,
  output logic [NUM_CH-1:0] o_active,
  output logic              o_busy,
  output logic              o_tick_drop
);
  localparam int DATA_W = 16;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // First pending channel at or after ptr, wrapping around.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] pend,
                                              input logic [CH_W-1:0]   ptr);
    logic [CH_W-1:0] pick;
    logic            found;
    int              j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && pend[j]) begin
        pick  = CH_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] ch);
    return (ch == LAST_CH) ? '0 : ch + CH_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic                tick_pend_q, tick_pend_d;
  logic                tick_drop_q, tick_drop_d;
  logic                vld_p0;

  logic [DATA_W-1:0]   cnt_q [NUM_CH];
  logic [DATA_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   active_q, active_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                exp_vld_q, exp_vld_d;
  logic [CH_W-1:0]     exp_ch_q, exp_ch_d;
  logic                ack;

  logic [DATA_W-1:0]   dec_res;
  logic                dec_borrow;
  logic                svc_act;
  logic                svc_expire;

`ifdef SCAN_TMR_AUTORELOAD_EN
  logic [DATA_W-1:0]   reload_q [NUM_CH];
`endif

  // Sweep sequencing and tick bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tick_pend_d = tick_pend_q;
    tick_drop_d = 1'b0;
    vld_p0      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_tick || tick_pend_q) begin
          state_d     = SWEEP;
          idx_d       = '0;
          // A fresh tick arriving while a deferred one is consumed stays queued.
          tick_pend_d = i_tick && tick_pend_q;
        end
      end
      SWEEP: begin
        vld_p0 = 1'b1;
        if (i_tick) begin
          if (tick_pend_q) tick_drop_d = 1'b1;
          else             tick_pend_d = 1'b1;
        end
        if (idx_q == LAST_CH) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Service stage p0: the channel under idx_q goes through the shared decrementer.
  minus_one #(.DATA_W(DATA_W)) u_dec (
    .a      (cnt_q[idx_q]),
    .y      (dec_res),
    .borrow (dec_borrow)
  );

  assign svc_act    = vld_p0 && active_q[idx_q];
  assign svc_expire = svc_act && (dec_borrow || (dec_res == '0));
  assign ack        = exp_vld_q && i_expire_rdy;

  // Per-channel counter/armed/pending update; cancel beats load beats service.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    pend_d   = pend_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ack && exp_ch_q == CH_W'(k)) pend_d[k] = 1'b0;
      if (svc_act && idx_q == CH_W'(k) && !(i_load_vld && i_load_ch == CH_W'(k))) begin
        if (svc_expire) begin
          pend_d[k] = 1'b1;
`ifdef SCAN_TMR_AUTORELOAD_EN
          cnt_d[k]  = reload_q[k];
`else
          cnt_d[k]    = '0;
          active_d[k] = 1'b0;
`endif
        end else begin
          cnt_d[k] = dec_res;
        end
      end
      if (i_load_vld && i_load_ch == CH_W'(k)) begin
        cnt_d[k]    = i_load_val;
        active_d[k] = 1'b1;
      end
      if (i_cancel_vld && i_cancel_ch == CH_W'(k)) begin
        active_d[k] = 1'b0;
        pend_d[k]   = 1'b0;
      end
    end
  end

  // Expiry port selection; a presented channel holds while stalled and still pending.
  always_comb begin
    rr_ptr_d  = ack ? ch_inc(exp_ch_q) : rr_ptr_q;
    exp_vld_d = |pend_d;
    if (exp_vld_q && !i_expire_rdy && pend_d[exp_ch_q]) exp_ch_d = exp_ch_q;
    else                                               exp_ch_d = rr_pick(pend_d, rr_ptr_d);
  end

  // Stage p0 -> p1 boundary: commit FSM, timers and expiry port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tick_pend_q <= 1'b0;
      tick_drop_q <= 1'b0;
      cnt_q       <= '{default: '0};
      active_q    <= '0;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      exp_vld_q   <= 1'b0;
      exp_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tick_pend_q <= tick_pend_d;
      tick_drop_q <= tick_drop_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      exp_vld_q   <= exp_vld_d;
      exp_ch_q    <= exp_ch_d;
    end
  end

`ifdef SCAN_TMR_AUTORELOAD_EN
  // Reload values are data only; every load refreshes the period.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_load_vld && i_load_ch == CH_W'(k)) reload_q[k] <= i_load_val;
    end
  end
`endif

  assign o_expire_vld = exp_vld_q;
  assign o_expire_ch  = exp_ch_q;
  assign o_active     = active_q;
  assign o_busy       = (state_q == SWEEP);
  assign o_tick_drop  = tick_drop_q;

endmodule

// File: tb/tb_scan_timer_sched.sv
// Bench for scan_timer_sched: directed scenarios plus random traffic, all
// compared every cycle against a cycle-numbered behavioural model.
module tb_scan_timer_sched;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst, tick, load_vld, cancel_vld, rdy;
  logic [CH_W-1:0]   load_ch, cancel_ch;
  logic [15:0]       load_val;
  logic              exp_vld;
  logic [CH_W-1:0]   exp_ch;
  logic [NUM_CH-1:0] active;
  logic              busy, drop;

  always #5 clk = ~clk;

  scan_timer_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tick       (tick),
    .i_load_vld   (load_vld),
    .i_load_ch    (load_ch),
    .i_load_val   (load_val),
    .i_cancel_vld (cancel_vld),
    .i_cancel_ch  (cancel_ch),
    .o_expire_vld (exp_vld),
    .o_expire_ch  (exp_ch),
    .i_expire_rdy (rdy),
    .o_active     (active),
    .o_busy       (busy),
    .o_tick_drop  (drop)
  );

  int checks = 0;
  int errors = 0;

  // Model: channel k is serviced in cycle base+k; cycles counted by cyc.
  int m_cnt [NUM_CH];
  int m_rel [NUM_CH];
  bit m_act [NUM_CH];
  bit m_pend[NUM_CH];
  int m_ptr, m_ch, cyc, base, last_tick;
  bit m_vld, m_tpend, m_drop;
  int acc [NUM_CH];

  function automatic bit m_busy(int c);
    return (c >= base) && (c < base + NUM_CH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k] = 0; m_act[k] = 0; m_pend[k] = 0;
    end
    m_ptr = 0; m_ch = 0; m_vld = 0; m_tpend = 0; m_drop = 0; base = -100;
  endtask

  task automatic model_step();
    int svc;
    bit ack, any, hold;
    int nc [NUM_CH];
    bit na [NUM_CH];
    bit np [NUM_CH];
    svc = m_busy(cyc) ? cyc - base : -1;
    m_drop = 0;
    if (svc < 0) begin
      if (tick || m_tpend) begin
        base    = cyc + 1;
        m_tpend = tick && m_tpend;
      end
    end else if (tick) begin
      if (m_tpend) m_drop = 1;
      else         m_tpend = 1;
    end
    nc = m_cnt; na = m_act; np = m_pend;
    ack = m_vld && rdy;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ack && m_ch == k) np[k] = 0;
      if (svc == k && m_act[k] && !(load_vld && int'(load_ch) == k)) begin
        if (m_cnt[k] <= 1) begin
          np[k] = 1;
`ifdef SCAN_TMR_AUTORELOAD_EN
          nc[k] = m_rel[k];
`else
          nc[k] = 0;
          na[k] = 0;
`endif
        end else begin
          nc[k] = m_cnt[k] - 1;
        end
      end
      if (load_vld && int'(load_ch) == k) begin
        nc[k] = int'(load_val); na[k] = 1; m_rel[k] = int'(load_val);
      end
      if (cancel_vld && int'(cancel_ch) == k) begin
        na[k] = 0; np[k] = 0;
      end
    end
    if (ack) m_ptr = (m_ch + 1) % NUM_CH;
    m_cnt = nc; m_act = na; m_pend = np;
    any = 0;
    for (int k = 0; k < NUM_CH; k++) any |= np[k];
    hold = m_vld && !rdy && np[m_ch];
    if (!hold) begin
      m_ch = 0;
      for (int j = NUM_CH - 1; j >= 0; j--)
        if (np[(m_ptr + j) % NUM_CH]) m_ch = (m_ptr + j) % NUM_CH;
    end
    m_vld = any;
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] a;
    for (int k = 0; k < NUM_CH; k++) a[k] = m_act[k];
    chk("active", 32'(active), 32'(a));
    chk("expire_vld", 32'(exp_vld), 32'(m_vld));
    chk("expire_ch", 32'(exp_ch), 32'(m_ch));
    chk("busy", 32'(busy), 32'(m_busy(cyc)));
    chk("tick_drop", 32'(drop), 32'(m_drop));
  endtask

  // One clock with the inputs currently driven, then full comparison.
  task automatic step();
    if (!rst && exp_vld && rdy) acc[exp_ch]++;
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic quiet();
    tick = 0; load_vld = 0; cancel_vld = 0;
  endtask

  task automatic do_load(input int ch, input int val);
    quiet();
    load_vld = 1; load_ch = CH_W'(ch); load_val = 16'(val);
    step();
    load_vld = 0;
  endtask

  task automatic do_tick();
    quiet(); tick = 1; step(); tick = 0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0; base = -100; last_tick = 0;
    for (int k = 0; k < NUM_CH; k++) begin acc[k] = 0; m_rel[k] = 0; end
    rst = 1; rdy = 0; load_ch = '0; load_val = '0; cancel_ch = '0;
    quiet();
    step(); step();
    chk("reset_vld", 32'(exp_vld), 0);
    chk("reset_active", 32'(active), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 0;
    idle(2);

    // Load 3, three ticks, expiry right after the third sweep reaches ch1.
    rdy = 1;
    do_load(1, 3);
    for (int t = 0; t < 2; t++) begin do_tick(); idle(9); end
    do_tick(); idle(2);
    chk("t1_vld", 32'(exp_vld), 1);
    chk("t1_ch", 32'(exp_ch), 1);
    chk("t1_active1", 32'(active[1]), 0);
    idle(1);
    chk("t1_vld_gone", 32'(exp_vld), 0);
    idle(4);

    // Two expiries stalled by rdy=0, then drained back to back.
    rdy = 0;
    do_load(0, 1);
    do_load(2, 1);
    do_tick(); idle(9);
    chk("t2_vld_held", 32'(exp_vld), 1);
    chk("t2_ch_held", 32'(exp_ch), 0);
    rdy = 1; idle(1);
    chk("t2_second_vld", 32'(exp_vld), 1);
    chk("t2_second_ch", 32'(exp_ch), 2);
    idle(1);
    chk("t2_drained", 32'(exp_vld), 0);
    idle(4);

    // Loaded with 0: borrow path expires, counter stays 0.
    rdy = 0;
    do_load(3, 0);
    do_tick(); idle(4);
    chk("t3_vld", 32'(exp_vld), 1);
    chk("t3_ch", 32'(exp_ch), 3);
    chk("t3_active3", 32'(active[3]), 0);
    chk("t3_cnt3", 32'(dut.cnt_q[3]), 0);
    rdy = 1; idle(6);

    // Ticks at T, T+1, T+2: second deferred, third dropped.
    rdy = 0;
    do_load(0, 2);
    quiet(); tick = 1; step(); step(); step(); tick = 0;
    chk("t4_drop", 32'(drop), 1);
    idle(1);
    chk("t4_drop_pulse", 32'(drop), 0);
    idle(3);
    chk("t4_second_sweep_vld", 32'(exp_vld), 1);
    chk("t4_second_sweep_ch", 32'(exp_ch), 0);
    rdy = 1; idle(6);

    // Load in the cycle ch2 is serviced wins over the decrement.
    do_load(2, 1);
    do_tick(); idle(2);
    do_load(2, 5);
    chk("t5_active2", 32'(active[2]), 1);
    chk("t5_no_expiry", 32'(exp_vld), 0);
    chk("t5_cnt2", 32'(dut.cnt_q[2]), 5);
    quiet(); load_vld = 1; load_ch = 2; load_val = 16'd7;
    cancel_vld = 1; cancel_ch = 2;
    step(); quiet();
    chk("t5_cancel_beats_load", 32'(active[2]), 0);
    idle(6);

`ifdef SCAN_TMR_AUTORELOAD_EN
    // Periodic timer: period 2, six ticks, three expiries, stays armed.
    rdy = 1;
    for (int k = 0; k < NUM_CH; k++) acc[k] = 0;
    do_load(0, 2);
    for (int t = 0; t < 6; t++) begin do_tick(); idle(7); end
    chk("ar_expiries", 32'(acc[0]), 3);
    chk("ar_active0", 32'(active[0]), 1);
    quiet(); cancel_vld = 1; cancel_ch = 0; step(); quiet();
    idle(6);
`endif

    // Random traffic with non-overlapping sweeps.
    last_tick = cyc;
    for (int i = 0; i < 800; i++) begin
      tick       = (cyc - last_tick >= NUM_CH + 1) && ($urandom_range(0, 3) == 0);
      if (tick) last_tick = cyc;
      load_vld   = ($urandom_range(0, 3) == 0);
      load_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      load_val   = 16'($urandom_range(0, 3));
      cancel_vld = ($urandom_range(0, 9) == 0);
      cancel_ch  = CH_W'($urandom_range(0, NUM_CH - 1));
      rdy        = ($urandom_range(0, 1) == 1);
      step();
    end
    idle(8);

    // Reset in the middle of a sweep aborts it.
    rdy = 0;
    do_load(1, 5);
    do_tick(); idle(1);
    chk("rst_mid_busy_before", 32'(busy), 1);
    rst = 1; quiet(); step(); rst = 0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_active", 32'(active), 0);
    chk("rst_mid_vld", 32'(exp_vld), 0);
    chk("rst_mid_ch", 32'(exp_ch), 0);
    chk("rst_mid_drop", 32'(drop), 0);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
